// File: rtl/frame_checker.sv
// frame_checker: AXI4-Stream sink that checks frames from the pseudo-random
// frame generator and keeps good/bad frame counts plus sticky error causes.
module frame_checker #(
    parameter int C_AXIS_DATA_WIDTH = 256,
    parameter int C_PACKET_LENGTH_WIDTH = 14,
    parameter int C_INPORT_WIDTH = 3,
    parameter int C_OUTPORT_WIDTH = 8,
    parameter int C_MAX_PACKET_SIZE = 9000,
    parameter logic [C_INPORT_WIDTH-1:0] C_IN_PORT = '0,
    parameter logic [C_INPORT_WIDTH-1:0] C_IN_VPORT = '0,
    parameter logic [C_OUTPORT_WIDTH-1:0] C_OUT_PORT = '0,
    parameter logic [C_OUTPORT_WIDTH-1:0] C_OUT_VPORT = '0,
    parameter bit C_BACKPRESSURE = 1'b0
) (
    input  logic                             clk,
    input  logic                             axi_reset,
    input  logic [C_AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]   s_axis_tkeep,
    input  logic [C_PACKET_LENGTH_WIDTH-1:0] s_axis_tuser_packet_length,
    input  logic [C_INPORT_WIDTH-1:0]        s_axis_tuser_in_port,
    input  logic [C_INPORT_WIDTH-1:0]        s_axis_tuser_in_vport,
    input  logic [C_OUTPORT_WIDTH-1:0]       s_axis_tuser_out_port,
    input  logic [C_OUTPORT_WIDTH-1:0]       s_axis_tuser_out_vport,
    input  logic                             s_axis_tvalid,
    output logic                             s_axis_tready,
    input  logic                             s_axis_tlast,
    output logic [31:0]                      pkt_ok_count,
    output logic [31:0]                      pkt_err_count,
    output logic [7:0]                       err_flags,
    output logic                             err_pulse
);
    localparam int LW = C_PACKET_LENGTH_WIDTH;
    localparam logic [31:0] MAXP = 32'(C_MAX_PACKET_SIZE);

    typedef enum logic [1:0] {IDLE, BODY, DRAIN} state_t;

    state_t state, state_nx;
    logic [15:0] lfsr;
    logic [31:0] seed_q, cnt_q, exp_cnt;
    logic [9:0] idx_q, k_c;
    logic bad_q, acc, chk, fend, fbad, last_k;
    logic [31:0] seed_c, cnt_c, len_v, len_c, nb_c, rem_c, keep_last;
    logic [255:0] exp_d, mask_d;
    logic [6:0] bf;

    assign acc = s_axis_tvalid & s_axis_tready;

    // Beat 0 is checked against its own word0; later beats use the latched seed.
    always_comb begin
        seed_c = (state == IDLE) ? s_axis_tdata[31:0] : seed_q;
        cnt_c = (state == IDLE) ? s_axis_tdata[255:224] : cnt_q;
        k_c = (state == IDLE) ? '0 : idx_q;
        len_v = 32'(seed_c[LW-1:0]);
        len_c = (len_v >= MAXP) ? len_v - MAXP : len_v;
        if (len_c < 32'd64) len_c = 32'd64;
        nb_c = (len_c + 32'd31) >> 5;
        rem_c = len_c - ((nb_c - 32'd1) << 5);
        keep_last = (rem_c == 32'd32) ? '1 : (32'd1 << rem_c) - 32'd1;
        last_k = (32'(k_c) == nb_c - 32'd1);
    end

    always_comb begin
        exp_d = '0;
        mask_d = '0;
        for (int i = 0; i < 8; i++) begin
            exp_d[32*i +: 32] = ((i % 2 == 1) ^ (k_c != '0 && !k_c[0]))
                              ? ~seed_c : seed_c;
        end
        for (int b = 0; b < 32; b++) begin
            mask_d[8*b +: 8] = {8{s_axis_tkeep[b]}};
        end
        if (k_c == '0) mask_d[255:224] = '0;
    end

    always_comb begin
        bf[0] = (k_c == '0) && (cnt_c != exp_cnt);
        bf[1] = |((s_axis_tdata ^ exp_d) & mask_d);
        bf[2] = s_axis_tuser_packet_length != len_c[LW-1:0];
        bf[3] = s_axis_tlast && !last_k;
        bf[4] = !s_axis_tlast && last_k;
        bf[5] = last_k ? (s_axis_tkeep != keep_last) : (s_axis_tkeep != '1);
        bf[6] = (s_axis_tuser_in_port != C_IN_PORT)
             || (s_axis_tuser_in_vport != C_IN_VPORT)
             || (s_axis_tuser_out_port != C_OUT_PORT)
             || (s_axis_tuser_out_vport != C_OUT_VPORT);
    end

    always_comb begin
        state_nx = state;
        fend = 1'b0;
        chk = acc && (state != DRAIN);
        unique case (state)
            IDLE, BODY: begin
                if (acc) begin
                    if (s_axis_tlast) begin
                        state_nx = IDLE;
                        fend = 1'b1;
                    end else if (last_k) begin
                        state_nx = DRAIN;
                    end else begin
                        state_nx = BODY;
                    end
                end
            end
            DRAIN: begin
                if (acc && s_axis_tlast) begin
                    state_nx = IDLE;
                    fend = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        fbad = bad_q | (chk & (|bf));
    end

    always_ff @(posedge clk or posedge axi_reset) begin
        if (axi_reset) begin
            state <= IDLE;
            lfsr <= 16'hACE1;
            s_axis_tready <= 1'b0;
            seed_q <= '0;
            cnt_q <= '0;
            exp_cnt <= 32'd1;
            idx_q <= '0;
            bad_q <= 1'b0;
            pkt_ok_count <= '0;
            pkt_err_count <= '0;
            err_flags <= '0;
            err_pulse <= 1'b0;
        end else begin
            state <= state_nx;
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            s_axis_tready <= C_BACKPRESSURE ? (lfsr[0] | lfsr[1]) : 1'b1;
            err_pulse <= 1'b0;
            if (acc && state == IDLE) begin
                seed_q <= s_axis_tdata[31:0];
                cnt_q <= s_axis_tdata[255:224];
            end
            if (chk) begin
                idx_q <= k_c + 10'd1;
                err_flags[6:0] <= err_flags[6:0] | bf;
            end
            if (state != IDLE && !s_axis_tvalid) err_flags[7] <= 1'b1;
            // Resync to the received counter so one lost frame costs one error.
            if (fend) begin
                bad_q <= 1'b0;
                exp_cnt <= cnt_c + 32'd1;
                if (fbad) begin
                    err_pulse <= 1'b1;
                    if (pkt_err_count != '1) pkt_err_count <= pkt_err_count + 32'd1;
                end else if (pkt_ok_count != '1) begin
                    pkt_ok_count <= pkt_ok_count + 32'd1;
                end
            end else if (chk) begin
                bad_q <= fbad;
            end
        end
    end
endmodule

// File: tb/tb_frame_checker.sv
// tb_frame_checker: randomized frames against a frame-level reference model
// of the checker's counts, sticky flags and error pulses.
module tb_frame_checker;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic axi_reset;
    logic [255:0] tdata;
    logic [31:0] tkeep;
    logic [13:0] tlen;
    logic [2:0] in_port, in_vport;
    logic [7:0] out_port, out_vport;
    logic tvalid, tlast, tready, pulse;
    logic [31:0] ok_cnt, err_cnt;
    logic [7:0] flags;
    logic tready_nb, pulse_nb;
    logic [31:0] ok_nb, err_nb;
    logic [7:0] flags_nb;

    int n_run = 0;
    int n_fail = 0;
    logic [31:0] m_exp_cnt, m_ok, m_err;
    logic [7:0] m_flags;
    int m_pulses = 0;
    int pulse_cnt = 0;
    int pulse_long = 0;
    int lo_cnt = 0;
    int hi_cnt = 0;
    logic pulse_prev = 1'b0;

    frame_checker #(.C_BACKPRESSURE(1'b1)) dut (
        .clk(clk), .axi_reset(axi_reset),
        .s_axis_tdata(tdata), .s_axis_tkeep(tkeep),
        .s_axis_tuser_packet_length(tlen),
        .s_axis_tuser_in_port(in_port), .s_axis_tuser_in_vport(in_vport),
        .s_axis_tuser_out_port(out_port), .s_axis_tuser_out_vport(out_vport),
        .s_axis_tvalid(tvalid), .s_axis_tready(tready), .s_axis_tlast(tlast),
        .pkt_ok_count(ok_cnt), .pkt_err_count(err_cnt),
        .err_flags(flags), .err_pulse(pulse)
    );

    frame_checker #(.C_BACKPRESSURE(1'b0)) dut_nb (
        .clk(clk), .axi_reset(axi_reset),
        .s_axis_tdata(tdata), .s_axis_tkeep(tkeep),
        .s_axis_tuser_packet_length(tlen),
        .s_axis_tuser_in_port(in_port), .s_axis_tuser_in_vport(in_vport),
        .s_axis_tuser_out_port(out_port), .s_axis_tuser_out_vport(out_vport),
        .s_axis_tvalid(1'b0), .s_axis_tready(tready_nb), .s_axis_tlast(tlast),
        .pkt_ok_count(ok_nb), .pkt_err_count(err_nb),
        .err_flags(flags_nb), .err_pulse(pulse_nb)
    );

    always @(negedge clk) begin
        if (pulse) pulse_cnt++;
        if (pulse && pulse_prev) pulse_long++;
        pulse_prev = pulse;
        if (tvalid && !axi_reset) begin
            if (tready) hi_cnt++;
            else lo_cnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int frame_len(input logic [31:0] s);
        int v;
        v = int'(s[13:0]);
        if (v >= 9000) v = v - 9000;
        if (v < 64) v = 64;
        return v;
    endfunction

    function automatic logic [31:0] rand_seed(input int v);
        logic [31:0] r;
        r = $urandom();
        r[13:0] = v[13:0];
        return r;
    endfunction

    task automatic do_reset();
        axi_reset = 1'b1;
        tvalid = 1'b0;
        tlast = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ok", ok_cnt, 0);
        check("rst_err", err_cnt, 0);
        check("rst_flags", flags, 0);
        check("rst_pulse", pulse, 0);
        check("rst_tready", tready, 0);
        check("rst_tready_nb", tready_nb, 0);
        m_exp_cnt = 32'd1;
        m_ok = 0;
        m_err = 0;
        m_flags = 0;
        axi_reset = 1'b0;
        @(negedge clk);
        check("rel_tready_nb", tready_nb, 1);
    endtask

    task automatic drive_beat(input logic [255:0] d, input logic [31:0] kp,
                              input bit last);
        bit done;
        done = 1'b0;
        tdata = d;
        tkeep = kp;
        tlast = last;
        tvalid = 1'b1;
        for (int c = 0; c < 200 && !done; c++) begin
            if (tready) done = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        check("beat_accept", done, 1);
    endtask

    task automatic send_frame(input string tag, input logic [31:0] seed,
                              input logic [31:0] ctr, input int tlast_at,
                              input int flip_beat, input logic [2:0] inp,
                              input bit bad_len, input bit bad_keep,
                              input bit gap, input int stop_at);
        int L, n, r, nsend;
        logic [31:0] lk, kp;
        logic [255:0] d;
        logic [7:0] f;
        bit inv, bad;
        L = frame_len(seed);
        n = (L + 31) / 32;
        r = L - 32 * (n - 1);
        lk = (r == 32) ? 32'hFFFF_FFFF : ((32'd1 << r) - 32'd1);
        nsend = (tlast_at >= 0) ? tlast_at + 1 : n;
        f = '0;
        f[0] = (ctr != m_exp_cnt);
        f[1] = (flip_beat >= 1) && (flip_beat < nsend) && (flip_beat < n);
        f[2] = bad_len;
        f[3] = (tlast_at >= 0) && (tlast_at < n - 1);
        f[4] = (tlast_at > n - 1);
        f[5] = bad_keep && (nsend >= n);
        f[6] = (inp != 3'd0);
        f[7] = gap && (nsend > 1);
        bad = |f[6:0];
        in_port = inp;
        in_vport = 3'd0;
        out_port = 8'd0;
        out_vport = 8'd0;
        tlen = bad_len ? 14'(L + 1) : 14'(L);
        for (int k = 0; k < nsend; k++) begin
            if (k == stop_at) begin
                tvalid = 1'b0;
                tlast = 1'b0;
                return;
            end
            for (int i = 0; i < 8; i++) begin
                inv = (i % 2 == 1) ^ (k > 0 && k % 2 == 0);
                d[32*i +: 32] = inv ? ~seed : seed;
            end
            if (k == 0) d[255:224] = ctr;
            if (k == flip_beat) d[7:0] = ~d[7:0];
            kp = (k == n - 1) ? lk : 32'hFFFF_FFFF;
            if (bad_keep && k == n - 1) kp[0] = 1'b0;
            drive_beat(d, kp, (k == nsend - 1));
            if (gap && k == 0 && nsend > 1) begin
                tvalid = 1'b0;
                @(negedge clk);
            end
        end
        tvalid = 1'b0;
        tlast = 1'b0;
        m_flags = m_flags | f;
        m_exp_cnt = ctr + 32'd1;
        if (bad) begin
            m_err++;
            m_pulses++;
        end else begin
            m_ok++;
        end
        check({tag, "_pulse"}, pulse, bad);
        check({tag, "_ok"}, ok_cnt, m_ok);
        check({tag, "_err"}, err_cnt, m_err);
        check({tag, "_flags"}, flags, m_flags);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lo0, hi0;
        axi_reset = 1'b1;
        tdata = '0;
        tkeep = '0;
        tlen = '0;
        in_port = '0;
        in_vport = '0;
        out_port = '0;
        out_vport = '0;
        tvalid = 1'b0;
        tlast = 1'b0;

        do_reset();
        send_frame("t1", 32'h0000_0040, 32'd1, -1, -1, 3'd0, 0, 0, 0, -1);

        do_reset();
        lo0 = lo_cnt;
        hi0 = hi_cnt;
        send_frame("t2", 32'h0000_2327, 32'd1, -1, -1, 3'd0, 0, 0, 0, -1);
        check("t2_ready_toggle", (lo_cnt > lo0) && (hi_cnt > hi0), 1);

        do_reset();
        send_frame("t3a", rand_seed(150), 32'd1, -1, -1, 3'd0, 0, 0, 0, -1);
        send_frame("t3b", rand_seed(90), 32'd2, -1, -1, 3'd0, 0, 0, 0, -1);
        send_frame("t3c", rand_seed(300), 32'd4, -1, -1, 3'd0, 0, 0, 0, -1);
        send_frame("t3d", rand_seed(64), 32'd5, -1, -1, 3'd0, 0, 0, 0, -1);

        do_reset();
        send_frame("t4a", rand_seed(100), 32'd1, 2, -1, 3'd0, 0, 0, 0, -1);
        send_frame("t4b", rand_seed(100), 32'd2, 6, -1, 3'd0, 0, 0, 0, -1);

        do_reset();
        send_frame("t5a", rand_seed(200), 32'd1, -1, 2, 3'd0, 0, 0, 0, -1);
        send_frame("t5b", rand_seed(200), 32'd2, -1, -1, 3'd2, 0, 0, 0, -1);

        do_reset();
        send_frame("t6a", rand_seed(128), 32'd1, -1, -1, 3'd0, 0, 0, 0, -1);
        send_frame("t6b", rand_seed(200), 32'd2, -1, -1, 3'd0, 0, 0, 0, 3);
        do_reset();
        send_frame("t6c", rand_seed(200), 32'd1, -1, -1, 3'd0, 0, 0, 0, -1);

        do_reset();
        for (int it = 0; it < 40; it++) begin
            int v, n, mode, tl, fl;
            logic [31:0] ctr;
            logic [2:0] ip;
            bit bl, bk, gp;
            if ($urandom_range(0, 7) == 0) v = $urandom_range(0, 16383);
            else if ($urandom_range(0, 3) == 0) v = 9000 + $urandom_range(0, 700);
            else v = $urandom_range(0, 700);
            n = (frame_len(32'(v)) + 31) / 32;
            if (it == 10) ctr = 32'hFFFF_FFFF;
            else if ($urandom_range(0, 7) == 0) ctr = m_exp_cnt + $urandom_range(1, 3);
            else ctr = m_exp_cnt;
            mode = $urandom_range(0, 11);
            tl = -1;
            fl = -1;
            ip = 3'd0;
            bl = 0;
            bk = 0;
            gp = ($urandom_range(0, 3) == 0);
            case (mode)
                0: fl = $urandom_range(1, n - 1);
                1: bl = 1;
                2: bk = 1;
                3: ip = 3'($urandom_range(1, 7));
                4: if (n >= 3) tl = $urandom_range(1, n - 2);
                5: tl = n + $urandom_range(0, 3);
                default: ;
            endcase
            send_frame("rnd", rand_seed(v), ctr, tl, fl, ip, bl, bk, gp, -1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("pulse_total", pulse_cnt, m_pulses);
        check("pulse_width", pulse_long, 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
